ex_mem_result_stage: RTL and testbench

- EX→MEM pipeline boundary, directly downstream of the combined ALU/FPU execute unit.
- Captures the execute result, destination info and write enables into the MEM-stage register.
- Generates the EX hold (stall) while a multi-cycle FPU operation is in flight, and buffers a finished FPU result when MEM is stalled.
- Provides an FPU hang watchdog and a stall-cycle performance counter.

---
 rtl/ex_mem_result_stage.sv | 203 ++++++++++++++++++++
 tb/tb_ex_mem_result_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_result_stage.sv
// EX->MEM pipeline register with multi-cycle FPU hold, one-entry skid buffer,
// FPU hang watchdog and stall-cycle counter.
module ex_mem_result_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned XLEN           = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid_ex,
  input  logic            i_fpu_multi,
  input  logic            i_done,
  input  logic [XLEN-1:0] i_result,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_rd_is_fp,
  input  logic            i_wr_en,
  input  logic            i_mem_stall,
  input  logic            i_flush,
  output logic            o_stall_ex,
  output logic            o_valid_mem,
  output logic [XLEN-1:0] o_result_mem,
  output logic [4:0]      o_rd_addr_mem,
  output logic            o_rd_is_fp_mem,
  output logic            o_wr_en_mem,
  output logic            o_fpu_timeout,
  output logic [31:0]     o_stall_cycles
);

  localparam int unsigned    WDW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WD_ONE = WDW'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_FPU = 2'd1,
    HOLD     = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WDW-1:0]    wd_q, wd_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_q, rd_d;
  logic              fp_q, fp_d;
  logic              wr_q, wr_d;
  logic [XLEN-1:0]   skid_result_q, skid_result_d;
  logic [4:0]        skid_rd_q, skid_rd_d;
  logic              skid_fp_q, skid_fp_d;
  logic              skid_wr_q, skid_wr_d;
  logic              timeout_q, timeout_d;
  logic [31:0]       stall_cnt_q;
  logic              stall_s;

  // Next-state, MEM-register load selection and EX hold generation.
  always_comb begin
    state_d       = state_q;
    wd_d          = wd_q;
    valid_d       = valid_q;
    result_d      = result_q;
    rd_d          = rd_q;
    fp_d          = fp_q;
    wr_d          = wr_q;
    skid_result_d = skid_result_q;
    skid_rd_d     = skid_rd_q;
    skid_fp_d     = skid_fp_q;
    skid_wr_d     = skid_wr_q;
    timeout_d     = timeout_q;
    stall_s       = i_mem_stall;

    case (state_q)
      IDLE: begin
        if (i_valid_ex && i_fpu_multi && !i_done && !i_flush) begin
          stall_s = 1'b1;
          state_d = WAIT_FPU;
          wd_d    = WD_ONE;
          if (!i_mem_stall) begin
            valid_d = 1'b0;
            wr_d    = 1'b0;
          end else begin
            valid_d = valid_q;
          end
        end else if (!i_mem_stall) begin
          valid_d  = i_valid_ex & ~i_flush;
          wr_d     = i_wr_en & i_valid_ex & ~i_flush;
          result_d = i_result;
          rd_d     = i_rd_addr;
          fp_d     = i_rd_is_fp;
        end else begin
          valid_d = valid_q;
        end
      end

      WAIT_FPU: begin
        wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + WD_ONE;
        if (i_flush) begin
          state_d = IDLE;
          if (!i_mem_stall) begin
            valid_d = 1'b0;
            wr_d    = 1'b0;
          end else begin
            valid_d = valid_q;
          end
        end else if (i_done) begin
          if (!i_mem_stall) begin
            stall_s  = 1'b0;
            state_d  = IDLE;
            valid_d  = 1'b1;
            wr_d     = i_wr_en;
            result_d = i_result;
            rd_d     = i_rd_addr;
            fp_d     = i_rd_is_fp;
          end else begin
            // MEM is busy: park the finished result and keep EX frozen.
            stall_s       = 1'b1;
            state_d       = HOLD;
            skid_result_d = i_result;
            skid_rd_d     = i_rd_addr;
            skid_fp_d     = i_rd_is_fp;
            skid_wr_d     = i_wr_en;
          end
        end else if (wd_q == WD_MAX) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
          if (!i_mem_stall) begin
            valid_d = 1'b0;
            wr_d    = 1'b0;
          end else begin
            valid_d = valid_q;
          end
        end else begin
          stall_s = 1'b1;
          if (!i_mem_stall) begin
            valid_d = 1'b0;
            wr_d    = 1'b0;
          end else begin
            valid_d = valid_q;
          end
        end
      end

      HOLD: begin
        stall_s = 1'b1;
        if (!i_mem_stall) begin
          state_d  = IDLE;
          valid_d  = 1'b1;
          wr_d     = skid_wr_q;
          result_d = skid_result_q;
          rd_d     = skid_rd_q;
          fp_d     = skid_fp_q;
        end else begin
          state_d = HOLD;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_stall_ex = stall_s & ~i_rst;

  // State, MEM register, skid buffer, watchdog and stall counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= IDLE;
      wd_q          <= '0;
      valid_q       <= 1'b0;
      result_q      <= '0;
      rd_q          <= 5'd0;
      fp_q          <= 1'b0;
      wr_q          <= 1'b0;
      skid_result_q <= '0;
      skid_rd_q     <= 5'd0;
      skid_fp_q     <= 1'b0;
      skid_wr_q     <= 1'b0;
      timeout_q     <= 1'b0;
      stall_cnt_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      valid_q       <= valid_d;
      result_q      <= result_d;
      rd_q          <= rd_d;
      fp_q          <= fp_d;
      wr_q          <= wr_d;
      skid_result_q <= skid_result_d;
      skid_rd_q     <= skid_rd_d;
      skid_fp_q     <= skid_fp_d;
      skid_wr_q     <= skid_wr_d;
      timeout_q     <= timeout_d;
      stall_cnt_q   <= o_stall_ex ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end
  end

  assign o_valid_mem    = valid_q;
  assign o_result_mem   = result_q;
  assign o_rd_addr_mem  = rd_q;
  assign o_rd_is_fp_mem = fp_q;
  assign o_wr_en_mem    = wr_q;
  assign o_fpu_timeout  = timeout_q;
  assign o_stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_result_stage.sv
// Directed test-plan scenarios plus randomized traffic, checked every cycle
// against a pending/parked-result reference model.
module tb_ex_mem_result_stage;
  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_ex = 1'b0, fpu_multi = 1'b0, done = 1'b0;
  logic [31:0] result = 32'd0;
  logic [4:0]  rd_addr = 5'd0;
  logic        rd_is_fp = 1'b0, wr_en = 1'b0, mem_stall = 1'b0, flush = 1'b0;
  logic        stall_ex, valid_mem, rd_is_fp_mem, wr_en_mem, fpu_timeout;
  logic [31:0] result_mem, stall_cycles;
  logic [4:0]  rd_addr_mem;

  int checks = 0;
  int errors = 0;

  ex_mem_result_stage #(.TIMEOUT_CYCLES(TO), .XLEN(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid_ex(valid_ex), .i_fpu_multi(fpu_multi),
    .i_done(done), .i_result(result), .i_rd_addr(rd_addr), .i_rd_is_fp(rd_is_fp),
    .i_wr_en(wr_en), .i_mem_stall(mem_stall), .i_flush(flush),
    .o_stall_ex(stall_ex), .o_valid_mem(valid_mem), .o_result_mem(result_mem),
    .o_rd_addr_mem(rd_addr_mem), .o_rd_is_fp_mem(rd_is_fp_mem),
    .o_wr_en_mem(wr_en_mem), .o_fpu_timeout(fpu_timeout),
    .o_stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Reference model: what MEM holds, whether an FPU op is outstanding,
  // and whether a finished result is parked waiting for MEM.
  bit          m_valid, m_fp, m_wr, m_timeout;
  bit [31:0]   m_result, m_stalls;
  bit [4:0]    m_rd;
  bit          m_pending, m_parked;
  int          m_waited;
  bit [31:0]   p_result;
  bit [4:0]    p_rd;
  bit          p_fp, p_wr;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_fp = 0; m_wr = 0; m_timeout = 0; m_result = 0; m_rd = 0;
    m_stalls = 0; m_pending = 0; m_parked = 0; m_waited = 0;
    p_result = 0; p_rd = 0; p_fp = 0; p_wr = 0;
  endtask

  task automatic mem_take(input bit v, input bit w, input bit [31:0] r, input bit [4:0] d, input bit f);
    m_valid = v; m_wr = w; m_result = r; m_rd = d; m_fp = f;
  endtask

  task automatic mem_bubble();
    m_valid = 0; m_wr = 0;
  endtask

  task automatic model_step(output bit st);
    st = mem_stall;
    if (m_parked) begin
      st = 1;
      if (!mem_stall) begin
        mem_take(1, p_wr, p_result, p_rd, p_fp);
        m_parked = 0;
      end
    end else if (m_pending) begin
      if (flush) begin
        m_pending = 0;
        if (!mem_stall) mem_bubble();
      end else if (done) begin
        m_pending = 0;
        if (!mem_stall) begin
          st = 0;
          mem_take(1, wr_en, result, rd_addr, rd_is_fp);
        end else begin
          st = 1;
          m_parked = 1;
          p_result = result; p_rd = rd_addr; p_fp = rd_is_fp; p_wr = wr_en;
        end
      end else if (m_waited >= int'(TO)) begin
        m_timeout = 1;
        m_pending = 0;
        if (!mem_stall) mem_bubble();
      end else begin
        st = 1;
        m_waited++;
        if (!mem_stall) mem_bubble();
      end
    end else if (valid_ex && fpu_multi && !done && !flush) begin
      st = 1;
      m_pending = 1;
      m_waited = 1;
      if (!mem_stall) mem_bubble();
    end else if (!mem_stall) begin
      mem_take(valid_ex & ~flush, wr_en & valid_ex & ~flush, result, rd_addr, rd_is_fp);
    end
    if (st) m_stalls++;
  endtask

  // Called at posedge+1 with inputs already applied; returns at next posedge+1.
  task automatic cycle();
    bit st;
    #1;
    model_step(st);
    check_val("stall_ex", {31'd0, stall_ex}, {31'd0, st});
    @(posedge clk);
    #1;
    check_val("valid_mem", {31'd0, valid_mem}, {31'd0, m_valid});
    check_val("wr_en_mem", {31'd0, wr_en_mem}, {31'd0, m_wr});
    check_val("fpu_timeout", {31'd0, fpu_timeout}, {31'd0, m_timeout});
    check_val("stall_cycles", stall_cycles, m_stalls);
    if (m_valid) begin
      check_val("result_mem", result_mem, m_result);
      check_val("rd_addr_mem", {27'd0, rd_addr_mem}, {27'd0, m_rd});
      check_val("rd_is_fp_mem", {31'd0, rd_is_fp_mem}, {31'd0, m_fp});
    end
  endtask

  task automatic drive(input bit v, input bit mu, input bit dn, input bit [31:0] r,
                       input bit [4:0] d, input bit f, input bit w, input bit ms, input bit fl);
    valid_ex = v; fpu_multi = mu; done = dn; result = r; rd_addr = d;
    rd_is_fp = f; wr_en = w; mem_stall = ms; flush = fl;
    cycle();
  endtask

  task automatic idle();
    drive(0, 0, 0, 32'd0, 5'd0, 0, 0, 0, 0);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_stall"}, {31'd0, stall_ex}, 32'd0);
    check_val({tag, "_valid"}, {31'd0, valid_mem}, 32'd0);
    check_val({tag, "_result"}, result_mem, 32'd0);
    check_val({tag, "_rd"}, {27'd0, rd_addr_mem}, 32'd0);
    check_val({tag, "_fp"}, {31'd0, rd_is_fp_mem}, 32'd0);
    check_val({tag, "_wr"}, {31'd0, wr_en_mem}, 32'd0);
    check_val({tag, "_timeout"}, {31'd0, fpu_timeout}, 32'd0);
    check_val({tag, "_stalls"}, stall_cycles, 32'd0);
  endtask

  task automatic do_reset();
    valid_ex = 0; fpu_multi = 0; done = 0; mem_stall = 0; flush = 0;
    rst = 1'b1;
    #2;
    model_reset();
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    rst = 1'b1;
    #1;
    check_zero("por");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Back-to-back ALU ops.
    drive(1, 0, 0, 32'h5, 5'd3, 0, 1, 0, 0);
    check_val("alu1_result", result_mem, 32'h5);
    drive(1, 0, 0, 32'hA, 5'd4, 0, 1, 0, 0);
    check_val("alu2_result", result_mem, 32'hA);
    check_val("alu2_rd", {27'd0, rd_addr_mem}, 32'd4);
    check_val("alu_stalls", stall_cycles, 32'd0);

    // FPU op completing four cycles after issue.
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 32'h3F800000, 5'd7, 1, 1, 0, 0);
    check_val("fpu_bubble", {31'd0, valid_mem}, 32'd0);
    drive(1, 1, 1, 32'h3F800000, 5'd7, 1, 1, 0, 0);
    check_val("fpu_result", result_mem, 32'h3F800000);
    check_val("fpu_rd", {27'd0, rd_addr_mem}, 32'd7);
    check_val("fpu_fp", {31'd0, rd_is_fp_mem}, 32'd1);
    check_val("fpu_stalls", stall_cycles, 32'd4);

    // Completion while MEM is stalled for three cycles.
    drive(1, 1, 0, 32'h40000000, 5'd9, 1, 1, 0, 0);
    drive(1, 1, 0, 32'h40000000, 5'd9, 1, 1, 0, 0);
    drive(1, 1, 1, 32'h40000000, 5'd9, 1, 1, 1, 0);
    drive(1, 1, 0, 32'h0, 5'd0, 0, 0, 1, 1);
    drive(1, 1, 0, 32'h0, 5'd0, 0, 0, 1, 0);
    check_val("hold_mem_frozen", {31'd0, valid_mem}, 32'd0);
    drive(1, 1, 0, 32'h0, 5'd0, 0, 0, 0, 0);
    check_val("hold_result", result_mem, 32'h40000000);
    check_val("hold_valid", {31'd0, valid_mem}, 32'd1);
    check_val("hold_stalls", stall_cycles, 32'd10);

    // Flush and done in the same wait cycle.
    drive(1, 1, 0, 32'h11, 5'd2, 0, 1, 0, 0);
    drive(1, 1, 0, 32'h11, 5'd2, 0, 1, 0, 0);
    drive(1, 1, 1, 32'h11, 5'd2, 0, 1, 0, 1);
    check_val("flush_valid", {31'd0, valid_mem}, 32'd0);
    check_val("flush_wr", {31'd0, wr_en_mem}, 32'd0);
    check_val("flush_stalls", stall_cycles, 32'd12);

    // Watchdog: done never arrives.
    for (int i = 0; i < int'(TO) + 1; i++) drive(1, 1, 0, 32'h22, 5'd6, 0, 1, 0, 0);
    check_val("wd_timeout", {31'd0, fpu_timeout}, 32'd1);
    check_val("wd_stalls", stall_cycles, 32'd20);
    drive(1, 0, 0, 32'h123, 5'd5, 0, 1, 0, 0);
    check_val("wd_alu_result", result_mem, 32'h123);
    check_val("wd_sticky", {31'd0, fpu_timeout}, 32'd1);

    // Asynchronous reset during the second wait cycle.
    drive(1, 1, 0, 32'h33, 5'd8, 1, 1, 0, 0);
    drive(1, 1, 0, 32'h33, 5'd8, 1, 1, 0, 0);
    valid_ex = 0; fpu_multi = 0; mem_stall = 0;
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 0, 1, 32'h33, 5'd8, 1, 1, 0, 0);
    check_val("late_done_ignored", {31'd0, valid_mem}, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 4,
              $urandom_range(0, 9) < 3, $urandom, 5'($urandom),
              1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
              $urandom_range(0, 19) < 2);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
